// File: rtl/sync_timing_recovery_if.sv
// Sync inputs and recovered timing outputs of sync_timing_recovery.
// master drives the syncs, slave is the recovery block.
interface sync_timing_recovery_if #(
  parameter int H_WIDTH = 11,
  parameter int V_WIDTH = 11
);
  logic               hsync_in;
  logic               vsync_in;
  logic [H_WIDTH-1:0] beam_x;
  logic [V_WIDTH-1:0] beam_y;
  logic [H_WIDTH-1:0] line_length;
  logic [H_WIDTH-1:0] hsync_width;
  logic [V_WIDTH-1:0] frame_lines;
  logic               locked;
  logic               timing_change;

  modport master (
    output hsync_in,
    output vsync_in,
    input  beam_x,
    input  beam_y,
    input  line_length,
    input  hsync_width,
    input  frame_lines,
    input  locked,
    input  timing_change
  );

  modport slave (
    input  hsync_in,
    input  vsync_in,
    output beam_x,
    output beam_y,
    output line_length,
    output hsync_width,
    output frame_lines,
    output locked,
    output timing_change
  );
endinterface

// File: rtl/sync_timing_recovery.sv
// Rebuilds beam position from hsync/vsync, measures line/frame
// timing and reports lock once several frames agree.
module sync_timing_recovery #(
  parameter int H_WIDTH          = 11,
  parameter int V_WIDTH          = 11,
  parameter int SYNC_ACTIVE_HIGH = 1,
  parameter int LOCK_FRAMES      = 2
) (
  input logic clock,
  input logic reset,
  sync_timing_recovery_if.slave bus
);

  typedef enum logic [1:0] {
    S_SEARCH,
    S_MEASURE,
    S_LOCKED
  } state_t;

  localparam logic [H_WIDTH-1:0] X_MAX = '1;
  localparam logic [V_WIDTH-1:0] Y_MAX = '1;
  localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);

  state_t r_state;
  state_t w_state_nx;

  logic r_hs_q;
  logic r_vs_q;
  logic r_vs_pend;

  logic [H_WIDTH-1:0] r_x;
  logic [V_WIDTH-1:0] r_y;
  logic [H_WIDTH-1:0] r_line_length;
  logic [H_WIDTH-1:0] r_hsync_width;
  logic [V_WIDTH-1:0] r_frame_lines;
  logic               r_locked;
  logic               r_timing_change;

  logic               r_have_first;
  logic [H_WIDTH-1:0] r_first;
  logic               r_bad;
  logic               r_have_ref;
  logic [3:0]         r_match;

  logic               w_hs;
  logic               w_vs;
  logic               w_hle;
  logic               w_vle;
  logic               w_hte;
  logic               w_fs;
  logic               w_x_sat;
  logic               w_y_sat;
  logic               w_timeout;
  logic [H_WIDTH-1:0] w_len;
  logic [V_WIDTH-1:0] w_height;
  logic [H_WIDTH-1:0] w_first_nx;
  logic               w_bad_nx;
  logic               w_ref_match;

  logic w_store;
  logic w_match;
  logic w_lock_set;
  logic w_drop;
  logic w_tout;
  logic w_clr_ref;

  assign w_hs = (SYNC_ACTIVE_HIGH != 0) ?
                bus.hsync_in : ~bus.hsync_in;
  assign w_vs = (SYNC_ACTIVE_HIGH != 0) ?
                bus.vsync_in : ~bus.vsync_in;

  assign w_hle = w_hs & ~r_hs_q;
  assign w_vle = w_vs & ~r_vs_q;
  assign w_hte = ~w_hs & r_hs_q;
  assign w_fs  = w_hle & (r_vs_pend | w_vle);

  assign w_x_sat   = (r_x == X_MAX);
  assign w_y_sat   = (r_y == Y_MAX);
  assign w_timeout = w_x_sat & ~w_hle;
  assign w_len     = r_x + H_WIDTH'(1);
  assign w_height  = r_y + V_WIDTH'(1);

  // The line just ended is part of the frame being closed, so
  // the frame verdict folds it in before the registers update.
  assign w_first_nx = r_have_first ? r_first : w_len;
  assign w_bad_nx   = r_bad | w_x_sat |
                      (r_have_first & (w_len != r_first)) |
                      (~w_fs & w_y_sat);
  assign w_ref_match = (w_first_nx == r_line_length) &
                       (w_height == r_frame_lines);

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_SEARCH;
    else       r_state <= w_state_nx;
  end

  // Next state and per-edge control decisions
  always_comb begin
    w_state_nx = r_state;
    w_store    = 1'b0;
    w_match    = 1'b0;
    w_lock_set = 1'b0;
    w_drop     = 1'b0;
    w_tout     = 1'b0;
    w_clr_ref  = 1'b0;
    unique case (r_state)
      S_SEARCH: begin
        if (w_fs) begin
          w_state_nx = S_MEASURE;
          w_clr_ref  = 1'b1;
        end
      end
      S_MEASURE: begin
        if (w_fs) begin
          if (!r_have_ref || w_bad_nx || !w_ref_match) begin
            w_store = 1'b1;
          end else begin
            w_match = 1'b1;
            if (r_match + 4'd1 == LOCK_N) begin
              w_lock_set = 1'b1;
              w_state_nx = S_LOCKED;
            end
          end
        end
      end
      S_LOCKED: begin
        if (w_hle && (w_x_sat ||
            (w_len != r_line_length) ||
            (w_fs && (w_height != r_frame_lines)))) begin
          w_drop     = 1'b1;
          w_state_nx = S_MEASURE;
        end
      end
      default: w_state_nx = S_SEARCH;
    endcase
    if (w_timeout) begin
      w_tout     = 1'b1;
      w_state_nx = S_SEARCH;
    end
  end

  // Sync history and pending vsync until the next hsync edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_hs_q    <= 1'b0;
      r_vs_q    <= 1'b0;
      r_vs_pend <= 1'b0;
    end else begin
      r_hs_q <= w_hs;
      r_vs_q <= w_vs;
      if (w_fs)       r_vs_pend <= 1'b0;
      else if (w_vle) r_vs_pend <= 1'b1;
    end
  end

  // Beam position counters, both saturating
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_x <= '0;
      r_y <= '0;
    end else begin
      if (w_hle)         r_x <= '0;
      else if (!w_x_sat) r_x <= w_len;
      if (w_fs)                    r_y <= '0;
      else if (w_hle && !w_y_sat)  r_y <= w_height;
    end
  end

  // Hsync pulse width from the trailing edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset)      r_hsync_width <= '0;
    else if (w_hte) r_hsync_width <= w_len;
  end

  // Per-frame consistency; a lock loss discards what was seen
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_have_first <= 1'b0;
      r_first      <= '0;
      r_bad        <= 1'b0;
    end else if (w_fs || w_drop) begin
      r_have_first <= 1'b0;
      r_bad        <= 1'b0;
    end else if (w_hle) begin
      r_have_first <= 1'b1;
      r_first      <= w_first_nx;
      r_bad        <= w_bad_nx;
    end
  end

  // Reference frame and consecutive-match count
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_line_length <= '0;
      r_frame_lines <= '0;
      r_have_ref    <= 1'b0;
      r_match       <= '0;
    end else if (w_clr_ref || w_drop || w_tout) begin
      r_have_ref <= 1'b0;
      r_match    <= '0;
    end else if (w_store) begin
      r_line_length <= w_first_nx;
      r_frame_lines <= w_height;
      r_have_ref    <= 1'b1;
      r_match       <= '0;
    end else if (w_match) begin
      r_match <= r_match + 4'd1;
    end
  end

  // Lock flag and one-cycle loss pulse
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_locked        <= 1'b0;
      r_timing_change <= 1'b0;
    end else begin
      r_timing_change <= w_drop | (w_tout & r_locked);
      if (w_lock_set)          r_locked <= 1'b1;
      else if (w_drop || w_tout) r_locked <= 1'b0;
    end
  end

  assign bus.beam_x        = r_x;
  assign bus.beam_y        = r_y;
  assign bus.line_length   = r_line_length;
  assign bus.hsync_width   = r_hsync_width;
  assign bus.frame_lines   = r_frame_lines;
  assign bus.locked        = r_locked;
  assign bus.timing_change = r_timing_change;

endmodule

// File: tb/tb_sync_timing_recovery.sv
// Bench for sync_timing_recovery: both sync polarities driven by
// one random raster stream and checked against a frame-level model.
module tb_sync_timing_recovery;
  localparam int HW   = 8;
  localparam int VW   = 8;
  localparam int LOCK = 2;
  localparam int XMAX = 255;

  logic clock;
  logic reset;
  logic hs;
  logic vs;

  int n_cmp = 0;
  int n_bad = 0;

  int m_st, m_y, m_rl, m_rh, m_hw, m_match, m_have;
  int m_locked, m_tc;
  int q[$];
  bit pend;
  int prev_len;

  sync_timing_recovery_if #(.H_WIDTH(HW), .V_WIDTH(VW)) ifh ();
  sync_timing_recovery_if #(.H_WIDTH(HW), .V_WIDTH(VW)) ifl ();

  assign ifh.hsync_in = hs;
  assign ifh.vsync_in = vs;
  assign ifl.hsync_in = ~hs;
  assign ifl.vsync_in = ~vs;

  sync_timing_recovery #(
    .H_WIDTH(HW), .V_WIDTH(VW),
    .SYNC_ACTIVE_HIGH(1), .LOCK_FRAMES(LOCK)
  ) dut_h (.clock(clock), .reset(reset), .bus(ifh));

  sync_timing_recovery #(
    .H_WIDTH(HW), .V_WIDTH(VW),
    .SYNC_ACTIVE_HIGH(0), .LOCK_FRAMES(LOCK)
  ) dut_l (.clock(clock), .reset(reset), .bus(ifl));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [31:0] oh,
                      input logic [31:0] ol, input logic [31:0] exp);
    chk({tag, "/hi"}, oh, exp);
    chk({tag, "/lo"}, ol, exp);
  endtask

  task automatic check_all();
    chk2("beam_x0", ifh.beam_x, ifl.beam_x, 0);
    chk2("beam_y", ifh.beam_y, ifl.beam_y, m_y);
    chk2("line_length", ifh.line_length, ifl.line_length, m_rl);
    chk2("hsync_width", ifh.hsync_width, ifl.hsync_width, m_hw);
    chk2("frame_lines", ifh.frame_lines, ifl.frame_lines, m_rh);
    chk2("locked", ifh.locked, ifl.locked, m_locked);
    chk2("timing_change", ifh.timing_change, ifl.timing_change,
         m_tc);
  endtask

  task automatic check_zero();
    chk2("rst_beam_x", ifh.beam_x, ifl.beam_x, 0);
    chk2("rst_beam_y", ifh.beam_y, ifl.beam_y, 0);
    chk2("rst_line_length", ifh.line_length, ifl.line_length, 0);
    chk2("rst_hsync_width", ifh.hsync_width, ifl.hsync_width, 0);
    chk2("rst_frame_lines", ifh.frame_lines, ifl.frame_lines, 0);
    chk2("rst_locked", ifh.locked, ifl.locked, 0);
    chk2("rst_tc", ifh.timing_change, ifl.timing_change, 0);
  endtask

  task automatic model_reset();
    m_st = 0; m_y = 0; m_rl = 0; m_rh = 0; m_hw = 0;
    m_match = 0; m_have = 0; m_locked = 0; m_tc = 0;
    q.delete();
    pend = 0;
  endtask

  // Frame-level view: lines are collected per frame and judged
  // when the frame start arrives.
  task automatic model_hle(input bit fs, input int plen);
    int meas, h;
    bit inv, cons;
    inv  = (plen > XMAX);
    meas = inv ? 0 : plen;
    h    = (m_y + 1) % 256;
    m_y  = fs ? 0 : ((m_y >= 255) ? 255 : m_y + 1);
    m_tc = 0;
    if (m_st == 2 &&
        (inv || meas != m_rl || (fs && h != m_rh))) begin
      m_locked = 0; m_tc = 1; m_st = 1;
      m_have = 0; m_match = 0;
      q.delete();
    end else begin
      q.push_back(inv ? -1 : meas);
      if (fs) begin
        if (m_st == 0) begin
          m_st = 1; m_have = 0; m_match = 0;
        end else if (m_st == 1) begin
          cons = 1;
          foreach (q[j]) if (q[j] != q[0] || q[j] < 0) cons = 0;
          if (m_have != 0 && cons && q[0] == m_rl &&
              h == m_rh) begin
            m_match++;
            if (m_match == LOCK) begin
              m_locked = 1; m_st = 2;
            end
          end else begin
            m_rl = (q[0] < 0) ? 0 : q[0];
            m_rh = h; m_match = 0; m_have = 1;
          end
        end
        q.delete();
      end
    end
  endtask

  task automatic model_timeout();
    m_locked = 0; m_st = 0; m_have = 0; m_match = 0;
  endtask

  task automatic send_line(input int len, input int hw,
                           input int rise, input int fall,
                           input int rst_at);
    bit fs;
    int wl;
    for (int i = 0; i < len; i++) begin
      @(negedge clock);
      if (rst_at >= 0 && i == rst_at + 2) reset = 1'b0;
      if (i == 0) begin
        fs = pend || (rise == 0 && !vs);
        pend = 0;
        model_hle(fs, prev_len);
      end
      if (i == 1) check_all();
      if (i == 2)
        chk2("tc_one_cycle", ifh.timing_change,
             ifl.timing_change, 0);
      if (i == hw + 1) m_hw = hw;
      if (i == XMAX + 2) begin
        wl = m_locked;
        model_timeout();
        chk2("timeout_tc", ifh.timing_change,
             ifl.timing_change, wl);
        chk2("timeout_locked", ifh.locked, ifl.locked, 0);
      end
      if (i == XMAX + 3)
        chk2("timeout_tc_end", ifh.timing_change,
             ifl.timing_change, 0);
      if (i == len - 1 && rst_at < 0)
        chk2("beam_x_end", ifh.beam_x, ifl.beam_x,
             (len - 2 > XMAX) ? XMAX : len - 2);
      if (i == rise) begin
        if (i > 0 && !vs) pend = 1;
        vs = 1'b1;
      end
      if (i == fall) vs = 1'b0;
      hs = (i < hw);
      if (i == rst_at) begin
        #1 reset = 1'b1;
        #1 check_zero();
        model_reset();
      end
    end
    prev_len = len;
  endtask

  task automatic send_frame(input int n, input int len,
                            input int hw, input bit early,
                            input int odd_k, input int odd_len,
                            input int rst_k, input int rst_at);
    int l, r, f;
    for (int k = 0; k < n; k++) begin
      l = (k == odd_k) ? odd_len : len;
      r = -1;
      f = -1;
      if (k == 0 && !vs) r = 0;
      if (k == 1) f = l / 2;
      if (k == n - 1 && early) r = l / 2;
      send_line(l, hw, r, f, (k == rst_k) ? rst_at : -1);
    end
  endtask

  initial begin
    int len, hw, n, n2;
    bit early;
    hs = 1'b0;
    vs = 1'b0;
    reset = 1'b1;
    prev_len = 0;
    model_reset();
    repeat (3) @(negedge clock);
    check_zero();
    reset = 1'b0;

    len   = $urandom_range(40, 90);
    hw    = $urandom_range(4, 10);
    n     = $urandom_range(6, 10);
    early = 1'($urandom_range(0, 1));
    repeat (6) send_frame(n, len, hw, early, -1, 0, -1, 0);
    chk2("nominal_locked", ifh.locked, ifl.locked, 1);
    chk2("nominal_len", ifh.line_length, ifl.line_length, len);
    chk2("nominal_hsw", ifh.hsync_width, ifl.hsync_width, hw);
    chk2("nominal_lines", ifh.frame_lines, ifl.frame_lines, n);

    send_frame(n, len, hw, early,
               $urandom_range(1, n - 1), len + 1, -1, 0);
    repeat (4) send_frame(n, len, hw, early, -1, 0, -1, 0);
    chk2("stretch_relock", ifh.locked, ifl.locked, 1);

    send_frame(n, len, hw, early, 2, 300, -1, 0);
    repeat (5) send_frame(n, len, hw, early, -1, 0, -1, 0);
    chk2("timeout_relock", ifh.locked, ifl.locked, 1);

    len   = $urandom_range(40, 90);
    hw    = $urandom_range(4, 10);
    n2    = $urandom_range(6, 9);
    early = 1'($urandom_range(0, 1));
    for (int f = 0; f < 6; f++)
      send_frame(n2 + (f % 2), len, hw, early, -1, 0, -1, 0);
    chk2("alt_unlocked", ifh.locked, ifl.locked, 0);

    repeat (5) send_frame(n, len, hw, early, -1, 0, -1, 0);
    chk2("pre_reset_locked", ifh.locked, ifl.locked, 1);
    send_frame(n, len, hw, early, -1, 0, 3, hw + 5);
    repeat (5) send_frame(n, len, hw, early, -1, 0, -1, 0);
    chk2("reset_relock", ifh.locked, ifl.locked, 1);
    chk2("reset_relock_len", ifh.line_length,
         ifl.line_length, len);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
